// File: rtl/morra_pkg.sv
// Shared types for the morra sequencing controller: FSM states, move encodings
// and round/match result codes as driven by the datapath.
package morra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        NULLA   = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_TIE  = 2'b11
    } res_e;

endpackage

// File: rtl/morra_move_slot.sv
// Single-entry move holder for one player: accepts a move while enabled and
// empty, holds it until cleared.
module morra_move_slot
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       valid,
    input  logic [1:0] move_in,
    output logic       ready,
    output logic       accept,
    output logic       full,
    output logic [1:0] move_out
);

    logic       full_q, full_d;
    logic [1:0] move_q, move_d;

    assign ready    = en & ~full_q;
    assign accept   = valid & ready;
    assign full     = full_q;
    assign move_out = move_q;

    // Clear wins over a same-cycle accept so an abort never leaves a stale move.
    always_comb begin
        full_d = full_q;
        move_d = move_q;
        if (clr) begin
            full_d = 1'b0;
            move_d = NULLA;
        end else if (accept) begin
            full_d = 1'b1;
            move_d = move_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            move_q <= NULLA;
        end else begin
            full_q <= full_d;
            move_q <= move_d;
        end
    end

endmodule

// File: rtl/morra_controller.sv
// Morra match sequencer: configures the datapath, pairs the two players' moves
// into rounds, enforces a per-round move timeout and latches the match result.
module morra_controller
    import morra_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ROUND_W        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               START,
    input  logic               ABORT,
    input  logic [3:0]         CFG,
    input  logic               P1_VALID,
    input  logic               P2_VALID,
    input  logic [1:0]         P1_MOVE,
    input  logic [1:0]         P2_MOVE,
    output logic               P1_READY,
    output logic               P2_READY,
    output logic               DP_INIZIO_SETUP,
    output logic               DP_INIZIO_CONTO,
    output logic               DP_FINE_CONTO,
    output logic [1:0]         DP_PRIMO,
    output logic [1:0]         DP_SECONDO,
    input  logic [1:0]         DP_MANCHE,
    input  logic [1:0]         DP_PARTITA,
    output logic               BUSY,
    output logic               DONE,
    output logic [1:0]         RISULTATO,
    output logic [ROUND_W-1:0] ROUND_CNT,
    output logic               TIMEOUT
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     to_cnt_q, to_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [1:0]           res_q, res_d;

    logic       collect, slot_clr;
    logic       acc1, acc2, full1, full2;
    logic [1:0] move1, move2;

    assign collect = (state_q == ST_COLLECT);

    morra_move_slot u_slot1 (
        .clk(clk), .rst_n(rst_n), .en(collect), .clr(slot_clr),
        .valid(P1_VALID), .move_in(P1_MOVE), .ready(P1_READY),
        .accept(acc1), .full(full1), .move_out(move1)
    );

    morra_move_slot u_slot2 (
        .clk(clk), .rst_n(rst_n), .en(collect), .clr(slot_clr),
        .valid(P2_VALID), .move_in(P2_MOVE), .ready(P2_READY),
        .accept(acc2), .full(full2), .move_out(move2)
    );

    always_comb begin
        state_d         = state_q;
        to_cnt_d        = '0;
        timeout_d       = 1'b0;
        round_d         = round_q;
        res_d           = res_q;
        slot_clr        = 1'b0;
        DP_INIZIO_SETUP = 1'b0;
        DP_INIZIO_CONTO = 1'b0;
        DP_FINE_CONTO   = 1'b0;
        DP_PRIMO        = NULLA;
        DP_SECONDO      = NULLA;

        case (state_q)
            ST_IDLE: if (START) state_d = ST_SETUP;
            ST_SETUP: begin
                DP_INIZIO_SETUP = 1'b1;
                DP_PRIMO        = CFG[1:0];
                DP_SECONDO      = CFG[3:2];
                round_d         = '0;
                res_d           = RES_NONE;
                slot_clr        = 1'b1;
                state_d         = ST_COLLECT;
            end
            ST_COLLECT: begin
                // A second move landing on the expiry cycle completes the round.
                if ((full1 | acc1) && (full2 | acc2)) begin
                    state_d = ST_ISSUE;
                end else if (full1 ^ full2) begin
                    if (to_cnt_q == TO_LAST) begin
                        slot_clr  = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                DP_INIZIO_CONTO = 1'b1;
                DP_PRIMO        = move1;
                DP_SECONDO      = move2;
                slot_clr        = 1'b1;
                state_d         = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (DP_MANCHE != RES_NONE && round_q != '1) round_d = round_q + 1'b1;
                if (DP_PARTITA != RES_NONE) begin
                    res_d         = DP_PARTITA;
                    DP_FINE_CONTO = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: if (START) state_d = ST_SETUP;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including the strobe the state would drive.
        if (ABORT && state_q != ST_IDLE) begin
            DP_INIZIO_SETUP = 1'b0;
            DP_INIZIO_CONTO = 1'b0;
            DP_FINE_CONTO   = 1'b1;
            DP_PRIMO        = NULLA;
            DP_SECONDO      = NULLA;
            slot_clr        = 1'b1;
            res_d           = RES_NONE;
            round_d         = round_q;
            timeout_d       = 1'b0;
            to_cnt_d        = '0;
            state_d         = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            round_q   <= '0;
            res_q     <= RES_NONE;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            round_q   <= round_d;
            res_q     <= res_d;
        end
    end

    assign BUSY      = (state_q == ST_SETUP) || collect ||
                       (state_q == ST_ISSUE) || (state_q == ST_WAIT_RES);
    assign DONE      = (state_q == ST_DONE);
    assign RISULTATO = res_q;
    assign ROUND_CNT = round_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_morra_controller.sv
// Bench for morra_controller: a behavioural morra datapath plus directed and
// randomized rounds checked against expectations derived from the game rules.
module tb_morra_controller;

    logic       clk, rst_n, START, ABORT;
    logic [3:0] CFG;
    logic       P1_VALID, P2_VALID;
    logic [1:0] P1_MOVE, P2_MOVE;
    logic       P1_READY, P2_READY;
    logic       DP_INIZIO_SETUP, DP_INIZIO_CONTO, DP_FINE_CONTO;
    logic [1:0] DP_PRIMO, DP_SECONDO, DP_MANCHE, DP_PARTITA;
    logic       BUSY, DONE, TIMEOUT;
    logic [1:0] RISULTATO;
    logic [4:0] ROUND_CNT;

    int checks = 0;
    int failures = 0;

    int         dp_target, dp_issued;
    logic [1:0] dp_result;
    int         exp_rounds, rounds_in_match;

    morra_controller #(.TIMEOUT_CYCLES(16), .ROUND_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .START(START), .ABORT(ABORT), .CFG(CFG),
        .P1_VALID(P1_VALID), .P2_VALID(P2_VALID), .P1_MOVE(P1_MOVE), .P2_MOVE(P2_MOVE),
        .P1_READY(P1_READY), .P2_READY(P2_READY),
        .DP_INIZIO_SETUP(DP_INIZIO_SETUP), .DP_INIZIO_CONTO(DP_INIZIO_CONTO),
        .DP_FINE_CONTO(DP_FINE_CONTO), .DP_PRIMO(DP_PRIMO), .DP_SECONDO(DP_SECONDO),
        .DP_MANCHE(DP_MANCHE), .DP_PARTITA(DP_PARTITA),
        .BUSY(BUSY), .DONE(DONE), .RISULTATO(RISULTATO), .ROUND_CNT(ROUND_CNT),
        .TIMEOUT(TIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rock-paper-scissors with NULLA as an invalid throw.
    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
            (a == 2'b11 && b == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction

    // Datapath model: registers the round verdict on the INIZIO_CONTO edge and
    // declares the match over on a scripted round number.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DP_MANCHE  <= 2'b00;
            DP_PARTITA <= 2'b00;
            dp_issued  <= 0;
        end else if (DP_INIZIO_SETUP) begin
            dp_issued <= 0;
        end else if (DP_INIZIO_CONTO) begin
            DP_MANCHE  <= judge(DP_PRIMO, DP_SECONDO);
            DP_PARTITA <= (dp_issued + 1 == dp_target) ? dp_result : 2'b00;
            dp_issued  <= dp_issued + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [18:0] all_outs();
        return {P1_READY, P2_READY, DP_INIZIO_SETUP, DP_INIZIO_CONTO, DP_FINE_CONTO,
                DP_PRIMO, DP_SECONDO, BUSY, DONE, RISULTATO, ROUND_CNT, TIMEOUT};
    endfunction

    // Starts in COLLECT with both slots empty; P1 offers at cycle d1, P2 at d2.
    task automatic play_round(input logic [1:0] m1, input logic [1:0] m2,
                              input int d1, input int d2);
        bit f1, f2, ends;
        f1 = 0;
        f2 = 0;
        for (int t = 0; t < 40 && !(f1 && f2); t++) begin
            P1_VALID = !f1 && t >= d1;
            P2_VALID = !f2 && t >= d2;
            P1_MOVE  = m1;
            P2_MOVE  = m2;
            #1;
            check("p1_ready", P1_READY, !f1);
            check("p2_ready", P2_READY, !f2);
            check("no_timeout", TIMEOUT, 0);
            check("no_conto_collect", DP_INIZIO_CONTO, 0);
            tick();
            if (P1_VALID) f1 = 1;
            if (P2_VALID) f2 = 1;
        end
        check("round_filled", f1 && f2, 1);
        P1_VALID = 0;
        P2_VALID = 0;
        #1;
        check("issue_conto", DP_INIZIO_CONTO, 1);
        check("issue_primo", DP_PRIMO, m1);
        check("issue_secondo", DP_SECONDO, m2);
        check("issue_ready", {P1_READY, P2_READY}, 2'b00);
        check("issue_timeout", TIMEOUT, 0);
        tick();
        rounds_in_match++;
        ends = (rounds_in_match == dp_target);
        if (judge(m1, m2) != 2'b00 && exp_rounds < 31) exp_rounds++;
        check("wait_fine", DP_FINE_CONTO, ends);
        check("wait_conto", DP_INIZIO_CONTO, 0);
        tick();
        check("round_cnt", ROUND_CNT, exp_rounds);
        check("done", DONE, ends);
        check("busy", BUSY, !ends);
        if (ends) check("risultato", RISULTATO, dp_result);
    endtask

    initial begin
        rst_n = 1; START = 0; ABORT = 0; CFG = 0;
        P1_VALID = 0; P2_VALID = 0; P1_MOVE = 0; P2_MOVE = 0;
        dp_target = 3; dp_result = 2'b10;
        exp_rounds = 0; rounds_in_match = 0;
        #3 rst_n = 0;
        #9;
        check("reset_outs", all_outs(), 0);
        rst_n = 1;
        tick();
        check("idle_outs", all_outs(), 0);

        // Setup
        START = 1; CFG = 4'b0110;
        tick();
        check("setup_strobe", DP_INIZIO_SETUP, 1);
        check("setup_primo", DP_PRIMO, 2'b10);
        check("setup_secondo", DP_SECONDO, 2'b01);
        check("setup_busy", BUSY, 1);
        START = 0;
        tick();
        check("collect_setup_off", DP_INIZIO_SETUP, 0);
        check("collect_ready", {P1_READY, P2_READY}, 2'b11);
        check("collect_primo", DP_PRIMO, 0);

        play_round(2'b10, 2'b01, 0, 0);
        play_round(2'b01, 2'b11, 0, 5);

        // Lone move expires
        P1_VALID = 1; P1_MOVE = 2'b11;
        tick();
        P1_VALID = 0;
        for (int k = 0; k < 16; k++) begin
            check("to_wait_pulse", TIMEOUT, 0);
            check("to_wait_ready", P1_READY, 0);
            check("to_wait_conto", DP_INIZIO_CONTO, 0);
            tick();
        end
        check("to_pulse", TIMEOUT, 1);
        check("to_ready_back", P1_READY, 1);
        check("to_no_conto", DP_INIZIO_CONTO, 0);
        check("to_busy", BUSY, 1);
        tick();
        check("to_pulse_end", TIMEOUT, 0);

        // Second move on the expiry cycle completes round 3, which ends the match
        play_round(2'b11, 2'b10, 0, 16);
        check("m1_round_cnt", ROUND_CNT, 3);

        // Restart from DONE, START held into COLLECT
        START = 1;
        tick();
        check("restart_setup", DP_INIZIO_SETUP, 1);
        check("restart_done_off", DONE, 0);
        tick();
        check("restart_round_clr", ROUND_CNT, 0);
        check("restart_res_clr", RISULTATO, 0);
        tick();
        check("start_ignored", DP_INIZIO_SETUP, 0);
        START = 0;
        dp_target = 100; exp_rounds = 0; rounds_in_match = 0;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] a, b;
            a = (i < 8) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
            b = (i < 8) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
            play_round(a, b, $urandom_range(0, 12), $urandom_range(0, 12));
        end
        check("round_saturated", ROUND_CNT, 31);

        // Abort in COLLECT with P1 holding a move
        P1_VALID = 1; P1_MOVE = 2'b01;
        tick();
        P1_VALID = 0; ABORT = 1;
        #1;
        check("abort_fine", DP_FINE_CONTO, 1);
        check("abort_no_conto", DP_INIZIO_CONTO, 0);
        tick();
        ABORT = 0;
        #1;
        check("abort_idle", {BUSY, DONE, DP_FINE_CONTO, P1_READY}, 0);
        check("abort_res", RISULTATO, 0);
        START = 1;
        tick();
        START = 0;
        tick();
        check("abort_slot_empty", {P1_READY, P2_READY}, 2'b11);

        // One-round match ending in a tie, then abort from DONE
        dp_target = 1; dp_result = 2'b11; exp_rounds = 0; rounds_in_match = 0;
        play_round(2'b00, 2'b10, 3, 1);
        ABORT = 1;
        #1;
        check("abort_done_fine", DP_FINE_CONTO, 1);
        tick();
        ABORT = 0;
        #1;
        check("abort_done_res", RISULTATO, 0);
        check("abort_done_flag", DONE, 0);

        // Reset during ISSUE
        START = 1;
        tick();
        START = 0;
        tick();
        P1_VALID = 1; P2_VALID = 1; P1_MOVE = 2'b10; P2_MOVE = 2'b11;
        tick();
        P1_VALID = 0; P2_VALID = 0;
        #1;
        check("pre_reset_conto", DP_INIZIO_CONTO, 1);
        rst_n = 0;
        #1;
        check("async_reset_outs", all_outs(), 0);
        tick();
        rst_n = 1;
        tick();
        check("post_reset_outs", all_outs(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morra_controller.md
Name: morra_controller

Overview:
- Sequencing controller for the morra game datapath (INIZIO_SETUP / INIZIO_CONTO / FINE_CONTO / PRIMO / SECONDO in, MANCHE / PARTITA out).
- Accepts independent valid/ready move streams from two players, configures the datapath at match start, and issues one round when both moves are held.
- Samples the round and match result, applies a per-round move timeout, and reports match completion.
- Sits between the player input front-ends and the datapath instance.

Parameters:
- TIMEOUT_CYCLES, 16: cycles allowed after the first move of a round before the pending move is discarded.
- ROUND_W, 5: width of the valid-round counter (saturating).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- START  in  1  request a new match (level, sampled in IDLE/DONE)
- ABORT  in  1  terminate current match
- CFG  in  4  match configuration; CFG[1:0] drives PRIMO, CFG[3:2] drives SECONDO during setup
- P1_VALID / P2_VALID  in  1  player move strobe
- P1_MOVE / P2_MOVE  in  2  player move
- P1_READY / P2_READY  out  1  player slot empty and accepting
- DP_INIZIO_SETUP  out  1  to datapath INIZIO_SETUP
- DP_INIZIO_CONTO  out  1  to datapath INIZIO_CONTO
- DP_FINE_CONTO  out  1  to datapath FINE_CONTO
- DP_PRIMO / DP_SECONDO  out  2  to datapath PRIMO / SECONDO
- DP_MANCHE  in  2  from datapath, round result
- DP_PARTITA  in  2  from datapath, match result
- BUSY  out  1  match in progress (SETUP..WAIT_RES)
- DONE  out  1  match finished, result held
- RISULTATO  out  2  latched DP_PARTITA at match end
- ROUND_CNT  out  ROUND_W  rounds with DP_MANCHE != 00
- TIMEOUT  out  1  one-cycle pulse on move timeout

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, except P1_READY / P2_READY = 0.
  - Slots empty; counters 0.
- Encodings:
  - Move: 00 NULLA, 01 SASSO, 10 CARTA, 11 FORBICE.
  - MANCHE: 00 invalid, 01 P1, 10 P2, 11 tie.
  - PARTITA: 00 ongoing, 01 P1, 10 P2, 11 tie.
- IDLE: START=1 -> SETUP.
- SETUP (1 cycle):
  - DP_INIZIO_SETUP=1, DP_PRIMO=CFG[1:0], DP_SECONDO=CFG[3:2].
  - Clear ROUND_CNT, RISULTATO, slots -> COLLECT.
- COLLECT:
  - Px_READY = slot x empty; move latched on Px_VALID & Px_READY.
  - Both players may be accepted in the same cycle.
  - Any move value is accepted, including 00; the datapath judges validity.
  - Both slots full at clock edge -> ISSUE next cycle.
- Timeout:
  - Counter starts on the first slot fill of the round and increments each cycle while exactly one slot is full.
  - On reaching TIMEOUT_CYCLES: the full slot is cleared, TIMEOUT pulses 1 cycle, the counter is cleared, and the state stays COLLECT.
  - If the second move arrives in the same cycle as the timeout, the move wins and there is no TIMEOUT.
- ISSUE (1 cycle):
  - DP_INIZIO_CONTO=1, DP_PRIMO=slot1, DP_SECONDO=slot2; READY=0.
  - Slots cleared at the end of the cycle -> WAIT_RES.
- WAIT_RES (1 cycle):
  - DP_MANCHE / DP_PARTITA are valid this cycle (datapath registers on the ISSUE edge).
  - If DP_MANCHE != 00, ROUND_CNT += 1, saturating at 2^ROUND_W-1.
  - If DP_PARTITA != 00: RISULTATO <= DP_PARTITA, DP_FINE_CONTO=1 this cycle -> DONE.
  - Otherwise -> COLLECT.
- DONE:
  - DONE=1; RISULTATO and ROUND_CNT held.
  - START=1 -> SETUP.
- ABORT, any non-IDLE state:
  - Has priority over START and every other transition.
  - DP_FINE_CONTO=1 for that cycle, slots cleared, RISULTATO=00, next state IDLE.
- Other rules:
  - Datapath strobes are mutually exclusive and never asserted for more than one consecutive cycle.
  - DP_PRIMO / DP_SECONDO = 00 whenever no strobe is active.
  - START held high across DONE restarts exactly once per DONE entry; it is sampled only in IDLE/DONE.
  - rst_n assertion mid-match returns to IDLE immediately with no FINE_CONTO pulse.

Decomposition:
- morra_pkg:
  - state enum (IDLE, SETUP, COLLECT, ISSUE, WAIT_RES, DONE);
  - move constants NULLA / SASSO / CARTA / FORBICE;
  - MANCHE / PARTITA result constants.
- Sub-module morra_move_slot, instantiated twice: per-player 2-bit hold register, full flag, READY generation, clear input.
- FSM, timeout counter and round counter live in the top level.

Test Plan:
- Setup: rst_n 0->1, START=1, CFG=4'b0110 -> DP_INIZIO_SETUP=1 one cycle with DP_PRIMO=10, DP_SECONDO=01; BUSY=1; READY both 1 next cycle.
- Simultaneous moves: P1=10, P2=01 same cycle -> DP_INIZIO_CONTO=1 next cycle with DP_PRIMO=10, DP_SECONDO=01; datapath model MANCHE=01 -> ROUND_CNT=1.
- Staggered moves: P1 at t, P2 at t+5 -> P1_READY=0 from t+1, single ISSUE; no TIMEOUT.
- Timeout: P1 only with TIMEOUT_CYCLES=16 -> TIMEOUT pulse 16 cycles after the fill; P1_READY back to 1; no DP_INIZIO_CONTO.
- Match end: model returns PARTITA=10 after the 3rd round -> DP_FINE_CONTO=1 in WAIT_RES, DONE=1, RISULTATO=10, ROUND_CNT=3; START restarts and clears ROUND_CNT.
- Abort and reset: ABORT in COLLECT with P1 slot full -> DP_FINE_CONTO one cycle, IDLE, RISULTATO=00; separately, rst_n=0 during ISSUE -> all outputs 0 asynchronously.
